// File: rtl/seg7_scan_decoder.sv
// Recovers a hex frame from a multiplexed active-low 7-segment bus by debouncing each digit dwell.
// Define SEG7_DP_CAPTURE_EN to capture per-digit decimal points and include them in stability.
module seg7_scan_decoder #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_err,
  output logic [DIGITS-1:0]     dp,
  output logic                  valid,
  output logic                  frame_done,
  output logic                  err
);

  typedef enum logic [1:0] {StWait, StSettle, StHeld} state_e;

`ifdef SEG7_DP_CAPTURE_EN
  localparam int unsigned SegW = 8;
`else
  localparam int unsigned SegW = 7;
`endif

  logic [SegW-1:0]       seg_q, prev_seg_q, prev_seg_d;
  logic [DIGITS-1:0]     an_q, prev_an_q, prev_an_d;
  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   sh_val_q, sh_val_d;
  logic [DIGITS-1:0]     sh_err_q, sh_err_d;
  logic [DIGITS-1:0]     mask_q, mask_d;
  logic [DIGITS-1:0]     sel;
  logic                  blank, legal, same, capture, commit, err_d;
  logic [4:0]            dec;

  function automatic logic [4:0] decode(input logic [6:0] pat);
    logic [4:0] r;
    r = 5'h10;
    case (pat)
      7'h3F: r = 5'h00;
      7'h06: r = 5'h01;
      7'h5B: r = 5'h02;
      7'h4F: r = 5'h03;
      7'h66: r = 5'h04;
      7'h6D: r = 5'h05;
      7'h7D: r = 5'h06;
      7'h07: r = 5'h07;
      7'h7F: r = 5'h08;
      7'h6F: r = 5'h09;
      7'h77: r = 5'h0A;
      7'h7C: r = 5'h0B;
      7'h39: r = 5'h0C;
      7'h5E: r = 5'h0D;
      7'h79: r = 5'h0E;
      7'h71: r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  assign sel   = ~an_q;
  assign blank = (sel == '0);
  assign legal = !blank && ((sel & (sel - DIGITS'(1))) == '0);
  assign same  = (seg_q == prev_seg_q) && (an_q == prev_an_q);
  assign dec   = decode(~seg_q[6:0]);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prev_seg_d = prev_seg_q;
    prev_an_d  = prev_an_q;
    capture    = 1'b0;
    err_d      = 1'b0;
    if (!legal) begin
      state_d = StWait;
      cnt_d   = '0;
      err_d   = !blank;
    end else begin
      prev_seg_d = seg_q;
      prev_an_d  = an_q;
      unique case (state_q)
        StWait: begin
          state_d = StSettle;
          cnt_d   = 4'd1;
        end
        StSettle: cnt_d = same ? cnt_q + 4'd1 : 4'd1;
        StHeld: begin
          if (!same) begin
            state_d = StSettle;
            cnt_d   = 4'd1;
          end
        end
        default: state_d = StWait;
      endcase
      // Capture on the cycle the count reaches the threshold, so one dwell captures once.
      if (state_d == StSettle && cnt_d == 4'(STABLE_CNT)) begin
        capture = 1'b1;
        state_d = StHeld;
      end
    end
  end

  always_comb begin
    sh_val_d = sh_val_q;
    sh_err_d = sh_err_q;
    mask_d   = mask_q;
    if (capture) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (sel[i]) begin
          sh_val_d[4*i +: 4] = dec[3:0];
          sh_err_d[i]        = dec[4];
          mask_d[i]          = 1'b1;
        end
      end
    end
    commit = capture && (&mask_d);
    if (commit) mask_d = '0;
  end

  // Sample registers reset to the deasserted (all ones) level so reset looks like a blank bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q      <= '1;
      an_q       <= '1;
      prev_seg_q <= '1;
      prev_an_q  <= '1;
      state_q    <= StWait;
      cnt_q      <= '0;
      sh_val_q   <= '0;
      sh_err_q   <= '0;
      mask_q     <= '0;
      value      <= '0;
      digit_err  <= '0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      seg_q      <= seg_n[SegW-1:0];
      an_q       <= an_n;
      prev_seg_q <= prev_seg_d;
      prev_an_q  <= prev_an_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_val_q   <= sh_val_d;
      sh_err_q   <= sh_err_d;
      mask_q     <= mask_d;
      frame_done <= commit;
      err        <= err_d;
      if (commit) begin
        value     <= sh_val_d;
        digit_err <= sh_err_d;
        valid     <= 1'b1;
      end
    end
  end

`ifdef SEG7_DP_CAPTURE_EN
  logic [DIGITS-1:0] sh_dp_q, sh_dp_d;

  always_comb begin
    sh_dp_d = sh_dp_q;
    if (capture) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (sel[i]) sh_dp_d[i] = ~seg_q[7];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_dp_q <= '0;
      dp      <= '0;
    end else begin
      sh_dp_q <= sh_dp_d;
      if (commit) dp <= sh_dp_d;
    end
  end
`else
  logic unused_dp_bit;
  assign unused_dp_bit = seg_n[7];
  assign dp            = '0;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed vector table, corner sequences and
// randomized scans checked against a run-length reference model.
module tb_seg7_scan_decoder;
  localparam int unsigned D  = 4;
  localparam int unsigned SC = 3;
`ifdef SEG7_DP_CAPTURE_EN
  localparam bit DpEn = 1'b1;
`else
  localparam bit DpEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     seg_n = 8'hFF;
  logic [D-1:0]   an_n = '1;
  logic [4*D-1:0] value;
  logic [D-1:0]   digit_err, dp;
  logic           valid, frame_done, err;

  seg7_scan_decoder #(.DIGITS(D), .STABLE_CNT(SC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .value      (value),
    .digit_err  (digit_err),
    .dp         (dp),
    .valid      (valid),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int fd_seen = 0;
  int err_seen = 0;

  logic [6:0] pat_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: a digit is captured when a legal sample has repeated SC times in a row.
  int             run;
  bit             prev_legal;
  logic [7:0]     prev_seg;
  logic [D-1:0]   prev_an;
  logic [3:0]     sh_val [D];
  bit             sh_err [D];
  bit             sh_dp  [D];
  bit             got    [D];
  logic [4*D-1:0] m_value;
  logic [D-1:0]   m_derr, m_dp;
  logic           m_valid, m_fd, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    run = 0;
    prev_legal = 0;
    prev_seg = '1;
    prev_an = '1;
    for (int i = 0; i < D; i++) begin
      sh_val[i] = 0; sh_err[i] = 0; sh_dp[i] = 0; got[i] = 0;
    end
    m_value = '0; m_derr = '0; m_dp = '0; m_valid = 0; m_fd = 0; m_err = 0;
  endtask

  task automatic model_step(input logic [7:0] s, input logic [D-1:0] a);
    int  lows, d, nib;
    bit  same, found, all;
    m_fd  = 0;
    m_err = 0;
    lows  = $countones(~a);
    if (lows != 1) begin
      prev_legal = 0;
      run = 0;
      m_err = (lows > 1);
    end else begin
      same = prev_legal && (a == prev_an) && (s[6:0] == prev_seg[6:0]) &&
             (!DpEn || s[7] == prev_seg[7]);
      run = same ? run + 1 : 1;
      prev_legal = 1;
      prev_seg = s;
      prev_an = a;
      if (run == SC) begin
        d = 0;
        for (int i = 0; i < D; i++) if (!a[i]) d = i;
        found = 0;
        nib = 0;
        for (int k = 0; k < 16; k++) if (pat_tbl[k] == ~s[6:0]) begin found = 1; nib = k; end
        sh_val[d] = 4'(nib);
        sh_err[d] = !found;
        sh_dp[d]  = DpEn && !s[7];
        got[d]    = 1;
        all = 1;
        for (int i = 0; i < D; i++) all = all && got[i];
        if (all) begin
          for (int i = 0; i < D; i++) begin
            m_value[4*i +: 4] = sh_val[i];
            m_derr[i] = sh_err[i];
            m_dp[i]   = sh_dp[i];
            got[i]    = 0;
          end
          m_valid = 1;
          m_fd = 1;
        end
      end
    end
  endtask

  // DUT outputs after this edge reflect every input driven up to the previous step.
  task automatic step(input logic [7:0] s, input logic [D-1:0] a);
    seg_n = s;
    an_n  = a;
    @(posedge clk);
    #1;
    check("value", 32'(value), 32'(m_value));
    check("digit_err", 32'(digit_err), 32'(m_derr));
    check("dp", 32'(dp), 32'(m_dp));
    check("valid", 32'(valid), 32'(m_valid));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("err", 32'(err), 32'(m_err));
    if (frame_done) fd_seen++;
    if (err) err_seen++;
    model_step(s, a);
  endtask

  task automatic hold(input logic [7:0] s, input logic [D-1:0] a, input int n);
    for (int i = 0; i < n; i++) step(s, a);
  endtask

  task automatic scan(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                      input logic [7:0] s3);
    hold(s0, 4'b1110, 8);
    hold(s1, 4'b1101, 8);
    hold(s2, 4'b1011, 8);
    hold(s3, 4'b0111, 8);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    seg_n = 8'hFF;
    an_n  = '1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    fd_seen = 0;
    err_seen = 0;
  endtask

  typedef struct {
    logic [7:0]   seg;
    logic [D-1:0] an;
    int           cycles;
    logic [15:0]  val;
    logic [3:0]   derr;
    logic         vld;
    int           fd;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [7:0]   s;
    logic [D-1:0] a;
    int           r;

    tbl[0]  = '{8'hF9, 4'b1110, 8, 16'h0000, 4'h0, 1'b0, 0};
    tbl[1]  = '{8'hA4, 4'b1101, 8, 16'h0000, 4'h0, 1'b0, 0};
    tbl[2]  = '{8'hB0, 4'b1011, 8, 16'h0000, 4'h0, 1'b0, 0};
    tbl[3]  = '{8'h99, 4'b0111, 8, 16'h4321, 4'h0, 1'b1, 1};
    tbl[4]  = '{8'hF9, 4'b1110, 8, 16'h4321, 4'h0, 1'b1, 1};
    tbl[5]  = '{8'hA4, 4'b1101, 8, 16'h4321, 4'h0, 1'b1, 1};
    tbl[6]  = '{8'hFF, 4'b1011, 8, 16'h4321, 4'h0, 1'b1, 1};
    tbl[7]  = '{8'h99, 4'b0111, 8, 16'h4021, 4'h4, 1'b1, 2};
    tbl[8]  = '{8'hF9, 4'b1110, 8, 16'h4021, 4'h4, 1'b1, 2};
    tbl[9]  = '{8'hA4, 4'b1101, 2, 16'h4021, 4'h4, 1'b1, 2};
    tbl[10] = '{8'hB0, 4'b1011, 8, 16'h4021, 4'h4, 1'b1, 2};
    tbl[11] = '{8'h99, 4'b0111, 8, 16'h4021, 4'h4, 1'b1, 2};
    tbl[12] = '{8'hA4, 4'b1101, 3, 16'h4021, 4'h4, 1'b1, 2};
    tbl[13] = '{8'hFF, 4'b1111, 3, 16'h4321, 4'h0, 1'b1, 3};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_value", 32'(value), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_pulses", 32'({frame_done, err}), 32'h0);
    do_reset();

    // Scans, undecodable digit, short dwell, and the 3-cycle boundary.
    for (int i = 0; i < 14; i++) begin
      hold(tbl[i].seg, tbl[i].an, tbl[i].cycles);
      check("tbl_value", 32'(value), 32'(tbl[i].val));
      check("tbl_digit_err", 32'(digit_err), 32'(tbl[i].derr));
      check("tbl_valid", 32'(valid), 32'(tbl[i].vld));
      check("tbl_frame_count", 32'(fd_seen), 32'(tbl[i].fd));
    end

    // Two enables low during digit 0 settling.
    do_reset();
    hold(8'hF9, 4'b1110, 2);
    hold(8'hF9, 4'b1100, 1);
    hold(8'hF9, 4'b1110, 2);
    hold(8'hA4, 4'b1101, 8);
    hold(8'hB0, 4'b1011, 8);
    hold(8'h99, 4'b0111, 8);
    check("illegal_err_count", 32'(err_seen), 32'd1);
    check("illegal_no_frame", 32'(fd_seen), 32'd0);
    hold(8'hF9, 4'b1110, 3);
    hold(8'hFF, 4'b1111, 3);
    check("restart_frame", 32'(fd_seen), 32'd1);
    check("restart_value", 32'(value), 32'h4321);

    // Reset with three of four digits captured.
    do_reset();
    scan(8'hF9, 8'hA4, 8'hB0, 8'h99);
    hold(8'hF9, 4'b1110, 8);
    hold(8'hA4, 4'b1101, 8);
    hold(8'hB0, 4'b1011, 8);
    rst_n = 1'b0;
    #1;
    check("async_rst_value", 32'(value), 32'h0);
    check("async_rst_valid", 32'(valid), 32'h0);
    check("async_rst_derr_dp", 32'({digit_err, dp}), 32'h0);
    #2;
    rst_n = 1'b1;
    model_reset();
    fd_seen = 0;
    hold(8'h99, 4'b0111, 8);
    check("post_rst_no_frame", 32'(fd_seen), 32'd0);
    check("post_rst_valid", 32'(valid), 32'h0);
    scan(8'hF9, 8'hA4, 8'hB0, 8'h99);
    check("post_rst_frame", 32'(fd_seen), 32'd1);
    check("post_rst_value", 32'(value), 32'h4321);

    // Decimal point on digit 3.
    do_reset();
    scan(8'hF9, 8'hA4, 8'hB0, 8'h19);
    check("dp_value", 32'(value), 32'h4321);
    check("dp_bits", 32'(dp), DpEn ? 32'h8 : 32'h0);

    // Randomized dwells against the model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 8) a = ~(4'b0001 << $urandom_range(0, 3));
      else if (r == 8) a = '1;
      else a = 4'($urandom);
      r = int'($urandom_range(0, 9));
      if (r < 8) s = {1'($urandom), ~pat_tbl[$urandom_range(0, 15)]};
      else s = 8'($urandom);
      hold(s, a, int'($urandom_range(1, 6)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter STABLE_CNT, default 3: consecutive identical registered samples required before a digit is captured, legal range 1..15.
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk, input, 1 bit, sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 seg_n  input  8  active-low segment bus; [6:0] = g,f,e,d,c,b,a; [7] = decimal point.
REQ-006 an_n  input  DIGITS  active-low digit enables; bit i selects digit i.
REQ-007 value  output  4*DIGITS  decoded hex frame; nibble i = digit i.
REQ-008 digit_err  output  DIGITS  bit i set = digit i held an undecodable pattern in the last frame.
REQ-009 dp  output  DIGITS  decimal-point state per digit in the last frame.
REQ-010 valid  output  1  at least one frame committed since reset.
REQ-011 frame_done  output  1  one-cycle pulse on frame commit.
REQ-012 err  output  1  one-cycle pulse on an illegal enable pattern.

Function
REQ-013 SHALL register seg_n and an_n once; all logic below operates on the registered sample.
REQ-014 Decode table, active-high pattern for nibbles 0..F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71; the pattern equals ~seg_n[6:0].
REQ-015 Any other 7-bit pattern SHALL decode to nibble 0 with the digit error flag set.
REQ-016 A sample SHALL be legal only when exactly one an_n bit is low.
REQ-017 an_n all high is a blank sample: counter cleared, state WAIT, no err.
REQ-018 Two or more an_n bits low: err pulses for one cycle, counter cleared, state WAIT.
REQ-019 FSM states: WAIT (no legal sample), SETTLE (counting), HELD (digit captured, awaiting change).
REQ-020 WAIT->SETTLE on a legal sample, with the counter loaded to 1.
REQ-021 In SETTLE, each identical sample increments the counter; a differing legal sample reloads the counter to 1.
REQ-022 When the counter reaches STABLE_CNT, the FSM SHALL capture the decoded nibble, error flag and DP into shadow slot i, set mask bit i, and go to HELD.
REQ-023 HELD->SETTLE on any differing legal sample; HELD->WAIT on a blank or illegal sample; a digit is captured at most once per dwell.
REQ-024 Latency: a stable input change SHALL reach the shadow slot STABLE_CNT+1 cycles later.
REQ-025 A recapture of an already-masked digit within a frame SHALL overwrite its shadow slot.
REQ-026 When the mask becomes all ones, the commit SHALL occur in the same cycle as the last capture and include that digit.
REQ-027 On commit: value, digit_err and dp load from the shadow; frame_done pulses; valid is set; the mask clears.
REQ-028 Outputs SHALL change only on commit; partial frames are never visible.

Reset
REQ-029 rst_n low SHALL asynchronously clear value, digit_err, dp, valid, frame_done, err, the mask, the shadow, the counter and the input registers, and force WAIT.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; the first commit after reset requires all DIGITS digits to be captured anew.

Configuration
REQ-031 Macro SEG7_DP_CAPTURE_EN defined: dp[i] SHALL be the inverted seg_n[7] captured with digit i, and seg_n[7] SHALL take part in the stability comparison.
REQ-032 Macro SEG7_DP_CAPTURE_EN undefined: dp SHALL be constant 0 and seg_n[7] SHALL be ignored everywhere.

Verification (DIGITS=4, STABLE_CNT=3)
REQ-033 Scan digits 0..3 with seg_n 8'hF9, A4, B0, 99 (an_n 1110, 1101, 1011, 0111), 8 cycles each -> value=16'h4321, digit_err=0, valid=1, exactly one frame_done pulse.
REQ-034 Digit 1 pattern held only 2 cycles inside a scan -> no capture, no frame_done until digit 1 is held for at least 3 cycles.
REQ-035 Digit 2 seg_n=8'hFF within an otherwise valid scan -> digit_err=4'b0100, nibble 2=0, other nibbles correct.
REQ-036 an_n=4'b1100 for 1 cycle during digit 0 settling -> err pulses once, digit 0 not captured, counting restarts.
REQ-037 rst_n pulsed low after 3 of 4 digits are captured -> all outputs 0 immediately; a full new scan is needed before frame_done.
REQ-038 With SEG7_DP_CAPTURE_EN, digit 3 seg_n=8'h19 -> dp=4'b1000 and nibble 3=4; without the macro -> dp=0 and nibble 3=4.
